// File: rtl/sync_tx_scheduler_pkg.sv
// Shared types and constants for the sync_tx_scheduler slice.
// Holds the FSM state enum, a clog2 helper and default HOLD/GAP.
package sync_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int HOLD_DEF = 4;
  localparam int GAP_DEF  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_tx_scheduler_if.sv
// Requester-side bundle: level req, packed words, one-hot ack.
// master = requesters, slave = scheduler.
interface sync_tx_scheduler_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   ack;

  modport master (
    output req,
    output req_data,
    input  ack
  );

  modport slave (
    input  req,
    input  req_data,
    output ack
  );

endinterface

// File: rtl/sync_tx_scheduler_arb.sv
// Combinational round-robin arbiter: search starts at last+1.
// Ports: req, last in; one-hot gnt, valid out.
module rr_arbiter
  import sync_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]        gnt,
  output logic                   valid
);

  // Pass 1 scans indices above last, pass 2 wraps to 0..last.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i] && i > int'(last)) begin
        gnt[i] = 1'b1;
        valid  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i] && i <= int'(last)) begin
        gnt[i] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_tx_scheduler.sv
// Shares one pulse_sync crossing among NREQ requesters.
// Ports: clk, rst_n, ena, rq (req/req_data/ack), sync_data, sync_stb, busy, grant_idx.
module sync_tx_scheduler
  import sync_sched_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int HOLD = HOLD_DEF,
  parameter int GAP  = GAP_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  sync_tx_scheduler_if.slave     rq,
  output logic [N-1:0]           sync_data,
  output logic                   sync_stb,
  output logic                   busy,
  output logic [clog2(NREQ)-1:0] grant_idx
);

  localparam int IW  = clog2(NREQ);
  localparam int MHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW  = clog2(MHG + 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0]  data_d, win_word;
  logic          stb_d;
  logic [IW-1:0] gidx_d, last, last_d, win;
  logic [NREQ-1:0] gnt;
  logic          gnt_vld;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (rq.req),
    .last  (last),
    .gnt   (gnt),
    .valid (gnt_vld)
  );

  always_comb begin
    win      = '0;
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win      = IW'(i);
        win_word = rq.req_data[i*N +: N];
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    data_d  = sync_data;
    stb_d   = sync_stb;
    gidx_d  = grant_idx;
    last_d  = last;
    if (ena) begin
      unique case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            state_d = S_HOLD;
            cnt_d   = CW'(HOLD - 1);
            data_d  = win_word;
            stb_d   = 1'b1;
            gidx_d  = win;
            last_d  = win;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state_d = S_GAP;
            cnt_d   = CW'(GAP - 1);
            stb_d   = 1'b0;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) state_d = S_IDLE;
          else cnt_d = cnt - 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          stb_d   = 1'b0;
        end
      endcase
    end
  end

  // Ack spans the final GAP cycle; while ena is low it is withheld
  // and reappears once ena returns, since the state is frozen.
  always_comb begin
    rq.ack = '0;
    if (ena && state == S_GAP && cnt == '0)
      rq.ack[grant_idx] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sync_data <= '0;
      sync_stb  <= 1'b0;
      grant_idx <= '0;
      last      <= IW'(NREQ - 1);
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sync_data <= data_d;
      sync_stb  <= stb_d;
      grant_idx <= gidx_d;
      last      <= last_d;
    end
  end

endmodule

// File: doc/sync_tx_scheduler.md
# sync_tx_scheduler

Source-domain scheduler that shares one `pulse_sync` crossing among several requesters. It arbitrates round-robin among pending requests and presents the winner's word on the synchronizer's `data_in`. It drives `stb` high for a programmed hold time, then keeps the data stable for a guard gap so the destination-side capture completes. It returns a one-cycle acknowledge to the winner, and all logic runs in the source clock domain.

## Interface
- `N`, 8: data width, matches the synchronizer's data width
- `NREQ`, 4: number of requesters (≥2)
- `HOLD`, 4: cycles `sync_stb` stays high (≥1; sized ≥ 3 destination periods by integrator)
- `GAP`, 4: cycles after `sync_stb` falls during which `sync_data` stays frozen (≥1)
- `clk`  in  1  source-domain clock; the block's single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  design enable; low freezes all state and outputs
- `req`  in  NREQ  per-requester level request, held until matching `ack`
- `req_data`  in  NREQ*N  packed words; slice i belongs to requester i and is stable while `req[i]` is high
- `sync_data`  out  N  word driven to the synchronizer's `data_in`
- `sync_stb`  out  1  strobe driven to the synchronizer's `stb`
- `ack`  out  NREQ  one-hot, one-cycle transfer-complete pulse
- `busy`  out  1  high in HOLD and GAP states
- `grant_idx`  out  clog2(NREQ)  index of current/last granted requester

## Operation
- FSM states: IDLE, HOLD, GAP. One down-counter, width clog2(max(HOLD,GAP)+1).
- IDLE: if `ena` and any `req` bit is set, pick a winner by round-robin. The search starts at `(last+1) mod NREQ`.
- IDLE on a grant: latch the winner's `req_data` slice into `sync_data` and set `grant_idx` and `last`. Load the counter with HOLD-1 and go to HOLD.
- HOLD: `sync_stb`=1. When the counter reaches 0, load GAP-1 and go to GAP; otherwise decrement.
- GAP: `sync_stb`=0 and `sync_data` unchanged. When the counter reaches 0, pulse `ack[grant_idx]` and go to IDLE; otherwise decrement.
- `sync_data` changes only on an IDLE→HOLD transition. It is never updated while `busy`.
- A requester dropping `req` mid-transfer does not abort the transfer. The transfer completes and `ack` still pulses.
- `req` changes during HOLD/GAP are ignored. Arbitration samples `req` only in IDLE.
- `ena`=0: state, counter, `sync_stb`, `sync_data` and `last` all hold. `ack` is forced to 0 and a pending ack is issued once `ena` returns.
- Reset values: state IDLE, `sync_stb`=0, `sync_data`=0, `ack`=0, `busy`=0, `grant_idx`=0, `last`=NREQ-1, so requester 0 wins first.
- Reset mid-transfer: immediate return to reset values and no ack. The `sync_stb` fall is valid because the synchronizer resets on the same `rst_n`.

## Timing
- All outputs are registered with no combinational path from `req` to outputs.
- Latency: `req` high in IDLE at edge t gives `sync_stb`=1 and valid `sync_data` after edge t.
- `sync_stb` is high for exactly HOLD cycles. It is then low for GAP cycles before `ack`.
- `ack` is high during the last GAP cycle, coincident with the GAP→IDLE edge.
- A transfer occupies 1+HOLD+GAP cycles, including one mandatory IDLE cycle. Back-to-back grants are therefore spaced 1+HOLD+GAP cycles apart.
- A requester sees `ack` and drops `req` at the next edge. It is never re-granted in the IDLE cycle that follows.
- Simultaneous requests resolve by round-robin only, with no fixed priority. With all `req` high, grants rotate 0,1,2,3,0…

## Structure
- Package `sync_sched_pkg` holds:
  - the state enum (IDLE/HOLD/GAP);
  - a `clog2` helper for counter and index widths;
  - default HOLD/GAP constants shared with the synchronizer instantiation.
- Sub-module `rr_arbiter` (NREQ): combinational. Inputs are `req` and `last`; outputs are a one-hot grant and `valid`.
- The top instantiates `rr_arbiter` beside the FSM/counter. A separate top-level wrapper connects `sync_data`/`sync_stb` to the synchronizer.

## Test plan
- Reset then single request: `req`=0001 with `req_data[7:0]`=0xA5. Expected: `sync_stb` high cycles 1–4, low 5–8; `sync_data`=0xA5 throughout; `ack`=0001 in cycle 8.
- All four requesting continuously, each with a distinct word (0x11,0x22,0x33,0x44). Expected: grant order 0,1,2,3,0, spaced 9 cycles apart, with `ack` bits matching in that order.
- Drop and data change mid-transfer: `req[2]` drops, and its data changes to 0xFF, during HOLD. Expected: `sync_data` stays at the original word and `ack[2]` still pulses in the last GAP cycle.
- `ena` low for 3 cycles during HOLD. Expected: `sync_stb` stays high 3 extra cycles; HOLD count resumes afterward; total strobe width HOLD+3.
- Async reset in the middle of GAP. Expected: all outputs 0 and no `ack`. The first grant after reset goes to requester 0 even with `req`=1111.
- Loopback through the synchronizer with clkB/clkA=0.7: 16 random words over 4 requesters. Expected: destination data register sequence equals the grant-order sequence, with no word lost or duplicated.
